booth_multiplier: RTL and testbench



---
 rtl/mul_div_pkg.sv | 20 ++
 rtl/booth_multiplier_control_path.sv | 98 +++++++++
 rtl/booth_multiplier.sv | 117 +++++++++++
 tb/tb_booth_multiplier.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and defaults for the sequential multiplier/divider family.
// State and Booth operation encodings are common to both control paths.
package mul_div_pkg;

    localparam int unsigned MUL_DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mul_div_state_e;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_e;

endpackage

// File: rtl/booth_multiplier_control_path.sv
// Booth multiplier sequencer: FSM, iteration count, busy/done and datapath strobes.
// BOOTH_UNSIGNED_SEL_EN adds one extra iteration for zero-extended operands.
module booth_multiplier_control_path
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_DIV_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      start,
    input  logic      q_lsb,
    input  logic      q_m1,
`ifdef BOOTH_UNSIGNED_SEL_EN
    input  logic      extra_iter,
`endif
    output logic      load_c,
    output booth_op_e op_c,
    output logic      shift_c,
    output logic      last_c,
    output logic      busy,
    output logic      done
);

`ifdef BOOTH_UNSIGNED_SEL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`else
    localparam int unsigned CNT_W = $clog2(WIDTH);
`endif

    mul_div_state_e   state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] last_cnt;

`ifdef BOOTH_UNSIGNED_SEL_EN
    assign last_cnt = extra_iter ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1);
`else
    assign last_cnt = CNT_W'(WIDTH - 1);
`endif

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_c  = 1'b0;
        op_c    = NOP;
        shift_c = 1'b0;
        last_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    count_d = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                unique case ({q_lsb, q_m1})
                    2'b01:   op_c = ADD;
                    2'b10:   op_c = SUB;
                    default: op_c = NOP;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (count_q == last_cnt) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = EVAL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; busy/done are registered decodes of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy    <= (state_q != IDLE);
            done    <= (state_q == DONE);
        end
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: datapath registers and adder, plus control path.
// BOOTH_UNSIGNED_SEL_EN adds is_signed to select zero-extended (unsigned) operands.
module booth_multiplier
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_SEL_EN
    input  logic               is_signed,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned AW = WIDTH + 1;
`ifdef BOOTH_UNSIGNED_SEL_EN
    localparam int unsigned QW = WIDTH + 1;
`else
    localparam int unsigned QW = WIDTH;
`endif
    localparam int unsigned PW = 2 * WIDTH;

    logic [AW-1:0] a_q, m_q, m_ext, a_eval, a_sh;
    logic [QW-1:0] q_q, q_ext, q_sh;
    logic          qm1_q;
    logic [PW-1:0] prod_c;
    logic          load_c, shift_c, last_c;
    booth_op_e     op_c;

`ifdef BOOTH_UNSIGNED_SEL_EN
    logic          uns_q;

    assign m_ext = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    assign q_ext = is_signed ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
`else
    assign m_ext = {multiplicand[WIDTH-1], multiplicand};
    assign q_ext = multiplier;
`endif

    booth_multiplier_control_path #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .q_lsb      (q_q[0]),
        .q_m1       (qm1_q),
`ifdef BOOTH_UNSIGNED_SEL_EN
        .extra_iter (uns_q),
`endif
        .load_c     (load_c),
        .op_c       (op_c),
        .shift_c    (shift_c),
        .last_c     (last_c),
        .busy       (busy),
        .done       (done)
    );

    // Add/sub evaluation on the extended accumulator
    always_comb begin
        a_eval = a_q;
        unique case (op_c)
            ADD:     a_eval = a_q + m_q;
            SUB:     a_eval = a_q - m_q;
            default: a_eval = a_q;
        endcase
    end

    assign a_sh = {a_q[AW-1], a_q[AW-1:1]};
    assign q_sh = {a_q[0], q_q[QW-1:1]};

    // In signed mode with a widened Q, the unused sign copy sits at the bottom of Q
`ifdef BOOTH_UNSIGNED_SEL_EN
    assign prod_c = uns_q ? {a_sh[WIDTH-2:0], q_sh} : {a_sh[WIDTH-1:0], q_sh[QW-1:1]};
`else
    assign prod_c = {a_sh[WIDTH-1:0], q_sh};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            product <= '0;
`ifdef BOOTH_UNSIGNED_SEL_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            if (load_c) begin
                a_q   <= '0;
                m_q   <= m_ext;
                q_q   <= q_ext;
                qm1_q <= 1'b0;
`ifdef BOOTH_UNSIGNED_SEL_EN
                uns_q <= ~is_signed;
`endif
            end else if (shift_c) begin
                a_q   <= a_sh;
                q_q   <= q_sh;
                qm1_q <= q_q[0];
            end else if (op_c != NOP) begin
                a_q   <= a_eval;
            end
            if (last_c) begin
                product <= prod_c;
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: arithmetic/timing model plus directed vectors.
// Define BOOTH_UNSIGNED_SEL_EN to also exercise the unsigned mode.
module tb_booth_multiplier;

    localparam int W = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   mc    = '0;
    logic [W-1:0]   mq    = '0;
`ifdef BOOTH_UNSIGNED_SEL_EN
    logic           is_signed = 1'b1;
`endif
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_chk  = 0;
    int n_fail = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mq),
`ifdef BOOTH_UNSIGNED_SEL_EN
        .is_signed    (is_signed),
`endif
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Plain integer multiply of the operands as signed or unsigned numbers
    function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                                                 input bit sgn);
        longint am, aq, p;
        logic [2*W-1:0] r;
        am = longint'(m);
        aq = longint'(q);
        if (sgn && m[W-1]) am = am - (longint'(1) << W);
        if (sgn && q[W-1]) aq = aq - (longint'(1) << W);
        p = am * aq;
        r = p[2*W-1:0];
        return r;
    endfunction

    // Model: an op accepted at edge a shows busy after edges a+1..a+2n+1,
    // done only after edge a+2n+1, product updated at edge a+2n, next accept at a+2n+2
    int             e      = 0;
    int             acc    = -1;
    int             iters  = W;
    bit             m_sgn  = 1'b1;
    logic [2*W-1:0] pend   = '0;
    logic [2*W-1:0] m_prod = '0;
    bit             exp_busy = 1'b0;
    bit             exp_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e        = 0;
            acc      = -1;
            m_prod   = '0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            e = e + 1;
            if (acc >= 0 && e == acc + 2*iters) m_prod = pend;
            if (acc >= 0 && e >= acc + 2*iters + 2) acc = -1;
            if (acc < 0 && start) begin
                m_sgn = 1'b1;
`ifdef BOOTH_UNSIGNED_SEL_EN
                m_sgn = is_signed;
`endif
                iters = m_sgn ? W : W + 1;
                pend  = model_mul(mc, mq, m_sgn);
                acc   = e;
            end
            exp_busy = (acc >= 0) && (e > acc) && (e <= acc + 2*iters + 1);
            exp_done = (acc >= 0) && (e == acc + 2*iters + 1);
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        chk("product", 64'(product), 64'(m_prod));
    end

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q, input bit sgn);
        @(negedge clk);
        start = 1'b1;
        mc    = m;
        mq    = q;
`ifdef BOOTH_UNSIGNED_SEL_EN
        is_signed = sgn;
`endif
        @(negedge clk);
        start = 1'b0;
        mc    = ~m;
        mq    = ~q;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] m, input logic [W-1:0] q,
                          input bit sgn, input logic [2*W-1:0] lit);
        int k;
        int it;
        it = sgn ? W : W + 1;
        launch(m, q, sgn);
        wait_done(k);
        chk({nm, "_latency"}, 64'(k), 64'(2*it + 1));
        chk({nm, "_product"}, 64'(product), 64'(lit));
        chk({nm, "_model"}, 64'(model_mul(m, q, sgn)), 64'(lit));
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("3x5",   4'h3, 4'h5, 1'b1, 8'h0F);
        run_op("m3x5",  4'hD, 4'h5, 1'b1, 8'hF1);
        run_op("7xm8",  4'h7, 4'h8, 1'b1, 8'hC8);
        run_op("m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);

        // Start re-pulsed with other operands while busy must be ignored
        launch(4'h2, 4'h3, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        mc    = 4'h1;
        mq    = 4'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("repulse_latency", 64'(k + 3), 64'(2*W + 1));
        chk("repulse_product", 64'(product), 64'h06);

        // Asynchronous reset in the middle of an operation
        launch(4'h5, 4'h3, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst_product", 64'(product), 64'd0);

        run_op("4x4", 4'h4, 4'h4, 1'b1, 8'h10);

        // Start held high: second op accepted in the IDLE cycle after DONE
        @(negedge clk);
        start = 1'b1;
        mc    = 4'h3;
        mq    = 4'h5;
        @(negedge clk);
        wait_done(k);
        chk("b2b1_latency", 64'(k), 64'(2*W + 1));
        chk("b2b1_product", 64'(product), 64'h0F);
        mc = 4'h6;
        mq = 4'hE;
        @(negedge clk);
        start = 1'b0;
        mc    = 4'h0;
        mq    = 4'h0;
        chk("b2b_gap_busy", 64'(busy), 64'd0);
        wait_done(k);
        chk("b2b2_latency", 64'(k), 64'(2*W + 1));
        chk("b2b2_product", 64'(product), 64'hF4);

`ifdef BOOTH_UNSIGNED_SEL_EN
        run_op("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
        run_op("s15x15", 4'hF, 4'hF, 1'b1, 8'h01);
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
